speed_sequencer: RTL and testbench
==================================

# speed_sequencer

Controller for the selectable-rate tick divider: it owns the divider's 2-bit `sel` input and decides when the tick rate changes. It takes start/stop and faster/slower requests and applies each rate change only on a divider tick boundary, so the tick period never gets a truncated or stretched interval. It counts delivered ticks and can optionally ramp the speed up on its own. It sits between user-input debouncing and the divider.

## Interface
- `RAMP_TICKS`, default 16: ticks spent at one level before an auto-ramp step; legal range 1..255.
- `clk_in`  input  1  system clock; every flop is on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  level; acted on only in IDLE.
- `stop`  input  1  level; highest priority in every state.
- `faster_req`  input  1  rising edge requests one step faster (`sel` − 1).
- `slower_req`  input  1  rising edge requests one step slower (`sel` + 1).
- `tick_in`  input  1  one-cycle pulse from the divider.
- `sel`  output  2  rate select to the divider: 1 = fastest, 3 = slowest, 0 = stopped.
- `run`  output  1  high in RUN and PEND.
- `level_changed`  output  1  one-cycle pulse in the cycle `sel` takes a new nonzero value.
- `tick_count`  output  8  ticks received since the last level change or start.

## Operation
- **Reset values:** state IDLE, `sel`=0, `run`=0, `level_changed`=0, `tick_count`=0, pending target cleared, edge-detect history cleared to 0.
- **States:** IDLE, RUN, PEND.
- **IDLE:**
  - `sel`=0.
  - `start`=1 → RUN. On entry: `sel`=3, `tick_count`=0, `level_changed` pulses.
- **RUN:**
  - Each `tick_in` increments `tick_count`; it wraps 255→0.
  - A valid request stores target = `sel`∓1 and moves to PEND.
  - A request that would leave 1..3 (faster at `sel`=1, slower at `sel`=3) is dropped: no state change, no pulse.
  - `faster_req` and `slower_req` rising in the same cycle: both dropped.
- **PEND:**
  - Further requests are ignored.
  - `tick_count` keeps counting.
  - On `tick_in`: `sel` := target, `tick_count` := 0, `level_changed` pulses, return to RUN.
- **Request detection:** edge detectors keep running in every state. An edge arriving in IDLE is discarded, not queued.
- **stop:**
  - `stop`=1 in any state → IDLE next cycle: `sel`=0, pending target cleared, `tick_count` held.
  - `stop` overrides `start` and requests arriving in the same cycle.
- **Auto-ramp:** see Configuration.

## Timing
- Request rising edge sampled at cycle N (input 0 at N−1, 1 at N) → state PEND at N+1.
- First `tick_in` sampled at cycle M ≥ N+1 → new `sel`, `tick_count`=0 and `level_changed`=1, all at M+1.
- Request and `tick_in` in the same RUN cycle: the tick is counted; the change waits for the next tick after entering PEND.
- `start` sampled at N → `run`=1, `sel`=3 at N+1.
- `stop` sampled at N → `run`=0, `sel`=0 at N+1.
- All outputs are registered; there is no combinational path from input to output.
- Asserting `rst` mid-PEND forces reset values immediately; the pending change is lost.

## Configuration
- Macro: `SPEED_SEQ_AUTORAMP_EN`.
- **Defined:**
  - In RUN, a `tick_in` arriving while `tick_count` = `RAMP_TICKS`−1 with `sel`>1 acts as an internal faster request.
  - That tick is counted, then the sequencer enters PEND; it applies on the next `tick_in`.
  - External requests in the same cycle take priority over the auto request.
  - At `sel`=1 there is no auto request; `tick_count` keeps counting and wrapping.
- **Undefined:** no auto requests; the level changes only on external requests. `RAMP_TICKS` is unused.

## Test plan
- Reset, then `start` pulse at cycle 5 → `sel`=3, `run`=1, `level_changed`=1 at cycle 6; `tick_count`=0.
- RUN at `sel`=3, `faster_req` rises at cycle 20, `tick_in` at cycle 30 → `sel` still 3 through cycle 30; `sel`=2 with `level_changed` pulse at cycle 31; `tick_count`=0.
- `sel`=1, `faster_req` pulse → no PEND, no pulse, `sel` stays 1. `faster_req` and `slower_req` rising together at `sel`=2 → no change.
- PEND with target 2, `stop` asserted together with `tick_in` → IDLE next cycle, `sel`=0, no `level_changed`; a later `start` gives `sel`=3.
- With `SPEED_SEQ_AUTORAMP_EN` and `RAMP_TICKS`=4 after `start`: the 4th tick enters PEND, the 5th tick gives `sel`=2; 4+1 more ticks give `sel`=1; after that `sel` holds 1 and `tick_count` reaches 255 then wraps to 0.
- Without the macro, 300 ticks after `start` → `sel` stays 3 and `tick_count` = 300 mod 256 = 44.

Source files
------------

// File: rtl/speed_sequencer.sv
// Rate-select controller for the tick divider: applies faster/slower steps only on tick boundaries.
// Optional auto-ramp is enabled by defining SPEED_SEQ_AUTORAMP_EN.
module speed_sequencer #(
    parameter int unsigned RAMP_TICKS = 16
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       faster_req,
    input  logic       slower_req,
    input  logic       tick_in,
    output logic [1:0] sel,
    output logic       run,
    output logic       level_changed,
    output logic [7:0] tick_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0] state;
    logic [1:0] target;
    logic       faster_d;
    logic       slower_d;
    logic       faster_rise;
    logic       slower_rise;
    logic       req_faster;
    logic       req_slower;
    logic       auto_faster;

    assign faster_rise = faster_req & ~faster_d;
    assign slower_rise = slower_req & ~slower_d;

    // Simultaneous opposite requests cancel; out-of-range steps are dropped.
    assign req_faster = faster_rise & ~slower_rise & (sel > 2'd1);
    assign req_slower = slower_rise & ~faster_rise & (sel < 2'd3);

`ifdef SPEED_SEQ_AUTORAMP_EN
    localparam logic [7:0] RAMP_LAST = 8'(RAMP_TICKS - 1);
    assign auto_faster = tick_in & (tick_count == RAMP_LAST) & (sel > 2'd1);
`else
    assign auto_faster = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            faster_d <= 1'b0;
            slower_d <= 1'b0;
        end else begin
            faster_d <= faster_req;
            slower_d <= slower_req;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            sel           <= 2'd0;
            run           <= 1'b0;
            level_changed <= 1'b0;
            tick_count    <= 8'd0;
            target        <= 2'd0;
        end else begin
            level_changed <= 1'b0;
            if (stop) begin
                state  <= ST_IDLE;
                sel    <= 2'd0;
                run    <= 1'b0;
                target <= 2'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        sel <= 2'd0;
                        if (start) begin
                            state         <= ST_RUN;
                            sel           <= 2'd3;
                            run           <= 1'b1;
                            tick_count    <= 8'd0;
                            level_changed <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (tick_in)
                            tick_count <= tick_count + 8'd1;
                        if (req_faster || (auto_faster && !req_slower)) begin
                            target <= sel - 2'd1;
                            state  <= ST_PEND;
                        end else if (req_slower) begin
                            target <= sel + 2'd1;
                            state  <= ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        if (tick_in) begin
                            sel           <= target;
                            tick_count    <= 8'd0;
                            level_changed <= 1'b1;
                            state         <= ST_RUN;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        sel   <= 2'd0;
                        run   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_speed_sequencer.sv
// Directed self-checking bench for speed_sequencer; covers the default build and, when
// SPEED_SEQ_AUTORAMP_EN is defined, the auto-ramp sequence with RAMP_TICKS=4.
module tb_speed_sequencer;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       faster_req = 1'b0;
    logic       slower_req = 1'b0;
    logic       tick_in = 1'b0;
    logic [1:0] sel;
    logic       run;
    logic       level_changed;
    logic [7:0] tick_count;

    int unsigned total = 0;
    int unsigned passed = 0;

    speed_sequencer #(.RAMP_TICKS(4)) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .faster_req    (faster_req),
        .slower_req    (slower_req),
        .tick_in       (tick_in),
        .sel           (sel),
        .run           (run),
        .level_changed (level_changed),
        .tick_count    (tick_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic cycle();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_sel, input logic e_run,
                             input logic e_lc, input logic [7:0] e_tc);
        check({tag, ".sel"}, 32'(sel), 32'(e_sel));
        check({tag, ".run"}, 32'(run), 32'(e_run));
        check({tag, ".lc"}, 32'(level_changed), 32'(e_lc));
        check({tag, ".tc"}, 32'(tick_count), 32'(e_tc));
    endtask

    // One tick pulse on its own cycle.
    task automatic do_tick();
        tick_in = 1'b1;
        cycle();
        tick_in = 1'b0;
    endtask

    task automatic faster_pulse();
        faster_req = 1'b1;
        cycle();
        faster_req = 1'b0;
        cycle();
    endtask

    task automatic slower_pulse();
        slower_req = 1'b1;
        cycle();
        slower_req = 1'b0;
        cycle();
    endtask

    initial begin
        cycle();
        cycle();
        check_out("reset", 2'd0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        cycle();

        start = 1'b1;
        cycle();
        start = 1'b0;
        check_out("start", 2'd3, 1'b1, 1'b1, 8'd0);
        cycle();
        check("start_lc_drop", 32'(level_changed), 32'd0);

        do_tick();
        do_tick();
        do_tick();
        check("count3", 32'(tick_count), 32'd3);

        faster_pulse();
        cycle();
        check_out("pend_hold", 2'd3, 1'b1, 1'b0, 8'd3);
        do_tick();
        check_out("to_sel2", 2'd2, 1'b1, 1'b1, 8'd0);

        // Request coinciding with a RUN tick: tick counted, change waits.
        slower_req = 1'b1;
        tick_in = 1'b1;
        cycle();
        slower_req = 1'b0;
        tick_in = 1'b0;
        check_out("req_tick_same", 2'd2, 1'b1, 1'b0, 8'd1);
        cycle();
        do_tick();
        check_out("to_sel3", 2'd3, 1'b1, 1'b1, 8'd0);

        faster_pulse();
        do_tick();
        faster_pulse();
        do_tick();
        check_out("to_sel1", 2'd1, 1'b1, 1'b1, 8'd0);

        faster_pulse();
        do_tick();
        check_out("faster_at_1", 2'd1, 1'b1, 1'b0, 8'd1);

        slower_pulse();
        do_tick();
        check_out("back_sel2", 2'd2, 1'b1, 1'b1, 8'd0);

        faster_req = 1'b1;
        slower_req = 1'b1;
        cycle();
        faster_req = 1'b0;
        slower_req = 1'b0;
        cycle();
        do_tick();
        check_out("both_req", 2'd2, 1'b1, 1'b0, 8'd1);

        // PEND toward 1; a slower edge while pending must be ignored.
        faster_pulse();
        slower_pulse();
        do_tick();
        check_out("pend_ignore", 2'd1, 1'b1, 1'b1, 8'd0);

        do_tick();
        slower_pulse();
        stop = 1'b1;
        tick_in = 1'b1;
        cycle();
        stop = 1'b0;
        tick_in = 1'b0;
        check_out("stop_pend", 2'd0, 1'b0, 1'b0, 8'd1);
        cycle();
        check_out("idle_hold", 2'd0, 1'b0, 1'b0, 8'd1);

        // Edge arriving in IDLE must not be queued.
        faster_pulse();
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_out("restart", 2'd3, 1'b1, 1'b1, 8'd0);
        cycle();
        do_tick();
        check_out("idle_edge_drop", 2'd3, 1'b1, 1'b0, 8'd1);

        faster_pulse();
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 2'd0, 1'b0, 1'b0, 8'd0);
        cycle();
        rst = 1'b0;
        cycle();
        do_tick();
        check_out("rst_lost_pend", 2'd0, 1'b0, 1'b0, 8'd0);

        start = 1'b1;
        cycle();
        start = 1'b0;
        check_out("start2", 2'd3, 1'b1, 1'b1, 8'd0);

`ifdef SPEED_SEQ_AUTORAMP_EN
        tick_in = 1'b1;
        repeat (4) cycle();
        check_out("ramp_pend", 2'd3, 1'b1, 1'b0, 8'd4);
        cycle();
        check_out("ramp_sel2", 2'd2, 1'b1, 1'b1, 8'd0);
        repeat (4) cycle();
        check_out("ramp_pend2", 2'd2, 1'b1, 1'b0, 8'd4);
        cycle();
        check_out("ramp_sel1", 2'd1, 1'b1, 1'b1, 8'd0);
        repeat (255) cycle();
        check_out("ramp_255", 2'd1, 1'b1, 1'b0, 8'd255);
        cycle();
        check_out("ramp_wrap", 2'd1, 1'b1, 1'b0, 8'd0);
        tick_in = 1'b0;
`else
        tick_in = 1'b1;
        repeat (300) cycle();
        tick_in = 1'b0;
        check_out("ticks300", 2'd3, 1'b1, 1'b0, 8'd44);
`endif

        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check("final_stop_sel", 32'(sel), 32'd0);
        check("final_stop_run", 32'(run), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
